reorder_buffer: RTL and testbench

//  In-order retirement buffer feeding the ARF commit port. Dispatch allocates up to 2 entries per cycle.

---
 rtl/reorder_buffer_pkg.sv | 15 +
 rtl/reorder_buffer.sv | 138 +++++++++++++
 tb/tb_reorder_buffer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths and the per-entry record for the reorder buffer.
package reorder_buffer_pkg;
  localparam int RRF_ENT_NUM     = 32;
  localparam int RRF_ENT_SEL     = 5;
  localparam int RV32_ARF_SEL    = 5;
  localparam int RV32_DATA_WIDTH = 32;

  typedef struct packed {
    logic                       valid;
    logic                       done;
    logic                       rd_wr_en;
    logic [RV32_ARF_SEL-1:0]    rd_addr;
    logic [RV32_DATA_WIDTH-1:0] data;
  } rob_ent_t;
endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dual dispatch allocate, dual writeback complete,
// dual in-order commit from the head into the ARF.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ENT_NUM = RRF_ENT_NUM,
  parameter int ENT_SEL = RRF_ENT_SEL
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_dp_vld_1,
  input  logic                       i_dp_vld_2,
  input  logic                       i_dp_rd_wr_en_1,
  input  logic                       i_dp_rd_wr_en_2,
  input  logic [RV32_ARF_SEL-1:0]    i_dp_rd_wr_addr_1,
  input  logic [RV32_ARF_SEL-1:0]    i_dp_rd_wr_addr_2,
  output logic                       o_dp_alloc_rdy,
  output logic [ENT_SEL-1:0]         o_dp_ptr_1,
  output logic [ENT_SEL-1:0]         o_dp_ptr_2,
  input  logic                       i_wb_vld_1,
  input  logic                       i_wb_vld_2,
  input  logic [ENT_SEL-1:0]         i_wb_rrftag_1,
  input  logic [ENT_SEL-1:0]         i_wb_rrftag_2,
  input  logic [RV32_DATA_WIDTH-1:0] i_wb_data_1,
  input  logic [RV32_DATA_WIDTH-1:0] i_wb_data_2,
  output logic                       o_com_vld_1,
  output logic                       o_com_vld_2,
  output logic                       o_com_rd_wr_en_1,
  output logic                       o_com_rd_wr_en_2,
  output logic [RV32_ARF_SEL-1:0]    o_com_rd_wr_addr_1,
  output logic [RV32_ARF_SEL-1:0]    o_com_rd_wr_addr_2,
  output logic [RV32_DATA_WIDTH-1:0] o_com_rd_wr_data_1,
  output logic [RV32_DATA_WIDTH-1:0] o_com_rd_wr_data_2
);

  // ENT_NUM is a power of two, so plain truncating add gives the wrap.
  function automatic logic [ENT_SEL-1:0] ptr_add(input logic [ENT_SEL-1:0] p,
                                                 input logic [1:0]         n);
    return p + ENT_SEL'(n);
  endfunction

  rob_ent_t           ent_q [ENT_NUM];
  rob_ent_t           ent_d [ENT_NUM];
  logic [ENT_SEL-1:0] head_q, head_d, tail_q, tail_d;
  logic [ENT_SEL:0]   count_q, count_d;

  logic               alloc_rdy, alloc_1, alloc_2, com_1, com_2;
  logic [ENT_SEL-1:0] head_1, tail_1;
  logic [1:0]         n_alloc, n_com;

  always_comb begin
    ent_d     = ent_q;
    alloc_rdy = count_q <= (ENT_SEL+1)'(ENT_NUM - 2);
    alloc_1   = i_dp_vld_1 & alloc_rdy;
    alloc_2   = i_dp_vld_2 & alloc_1;
    head_1    = ptr_add(head_q, 2'd1);
    tail_1    = ptr_add(tail_q, 2'd1);
    com_1     = (count_q != '0) & ent_q[head_q].valid & ent_q[head_q].done;
    com_2     = com_1 & ent_q[head_1].valid & ent_q[head_1].done;
    n_alloc   = {1'b0, alloc_1} + {1'b0, alloc_2};
    n_com     = {1'b0, com_1} + {1'b0, com_2};

    // Port 2 is applied last so it wins a same-tag collision.
    if (i_wb_vld_1 && ent_q[i_wb_rrftag_1].valid) begin
      ent_d[i_wb_rrftag_1].done = 1'b1;
      ent_d[i_wb_rrftag_1].data = i_wb_data_1;
    end
    if (i_wb_vld_2 && ent_q[i_wb_rrftag_2].valid) begin
      ent_d[i_wb_rrftag_2].done = 1'b1;
      ent_d[i_wb_rrftag_2].data = i_wb_data_2;
    end

    if (com_1) begin
      ent_d[head_q].valid = 1'b0;
      ent_d[head_q].done  = 1'b0;
    end
    if (com_2) begin
      ent_d[head_1].valid = 1'b0;
      ent_d[head_1].done  = 1'b0;
    end

    // Allocation comes after writeback so a same-cycle writeback is discarded.
    if (alloc_1) begin
      ent_d[tail_q].valid    = 1'b1;
      ent_d[tail_q].done     = 1'b0;
      ent_d[tail_q].rd_wr_en = i_dp_rd_wr_en_1;
      ent_d[tail_q].rd_addr  = i_dp_rd_wr_addr_1;
    end
    if (alloc_2) begin
      ent_d[tail_1].valid    = 1'b1;
      ent_d[tail_1].done     = 1'b0;
      ent_d[tail_1].rd_wr_en = i_dp_rd_wr_en_2;
      ent_d[tail_1].rd_addr  = i_dp_rd_wr_addr_2;
    end

    head_d  = ptr_add(head_q, n_com);
    tail_d  = ptr_add(tail_q, n_alloc);
    count_d = count_q + (ENT_SEL+1)'(n_alloc) - (ENT_SEL+1)'(n_com);

    if (i_flush) begin
      for (int i = 0; i < ENT_NUM; i++) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENT_NUM; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ENT_NUM; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_dp_alloc_rdy     = alloc_rdy;
  assign o_dp_ptr_1         = tail_q;
  assign o_dp_ptr_2         = tail_1;
  assign o_com_vld_1        = com_1;
  assign o_com_vld_2        = com_2;
  assign o_com_rd_wr_en_1   = com_1 & ent_q[head_q].rd_wr_en;
  assign o_com_rd_wr_en_2   = com_2 & ent_q[head_1].rd_wr_en;
  assign o_com_rd_wr_addr_1 = ent_q[head_q].rd_addr;
  assign o_com_rd_wr_addr_2 = ent_q[head_1].rd_addr;
  assign o_com_rd_wr_data_1 = ent_q[head_q].data;
  assign o_com_rd_wr_data_2 = ent_q[head_1].data;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a reference model and commit scoreboard.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_dp_vld_1 = 0, i_dp_vld_2 = 0, i_dp_rd_wr_en_1 = 0, i_dp_rd_wr_en_2 = 0;
  logic [4:0]  i_dp_rd_wr_addr_1 = 0, i_dp_rd_wr_addr_2 = 0;
  logic        o_dp_alloc_rdy;
  logic [4:0]  o_dp_ptr_1, o_dp_ptr_2;
  logic        i_wb_vld_1 = 0, i_wb_vld_2 = 0;
  logic [4:0]  i_wb_rrftag_1 = 0, i_wb_rrftag_2 = 0;
  logic [31:0] i_wb_data_1 = 0, i_wb_data_2 = 0;
  logic        o_com_vld_1, o_com_vld_2, o_com_rd_wr_en_1, o_com_rd_wr_en_2;
  logic [4:0]  o_com_rd_wr_addr_1, o_com_rd_wr_addr_2;
  logic [31:0] o_com_rd_wr_data_1, o_com_rd_wr_data_2;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_dp_vld_1(i_dp_vld_1), .i_dp_vld_2(i_dp_vld_2),
    .i_dp_rd_wr_en_1(i_dp_rd_wr_en_1), .i_dp_rd_wr_en_2(i_dp_rd_wr_en_2),
    .i_dp_rd_wr_addr_1(i_dp_rd_wr_addr_1), .i_dp_rd_wr_addr_2(i_dp_rd_wr_addr_2),
    .o_dp_alloc_rdy(o_dp_alloc_rdy), .o_dp_ptr_1(o_dp_ptr_1), .o_dp_ptr_2(o_dp_ptr_2),
    .i_wb_vld_1(i_wb_vld_1), .i_wb_vld_2(i_wb_vld_2),
    .i_wb_rrftag_1(i_wb_rrftag_1), .i_wb_rrftag_2(i_wb_rrftag_2),
    .i_wb_data_1(i_wb_data_1), .i_wb_data_2(i_wb_data_2),
    .o_com_vld_1(o_com_vld_1), .o_com_vld_2(o_com_vld_2),
    .o_com_rd_wr_en_1(o_com_rd_wr_en_1), .o_com_rd_wr_en_2(o_com_rd_wr_en_2),
    .o_com_rd_wr_addr_1(o_com_rd_wr_addr_1), .o_com_rd_wr_addr_2(o_com_rd_wr_addr_2),
    .o_com_rd_wr_data_1(o_com_rd_wr_data_1), .o_com_rd_wr_data_2(o_com_rd_wr_data_2)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; logic wen; logic [4:0] addr; } exp_t;
  exp_t        sbq[$];
  bit          mvalid[32], mdone[32];
  logic [31:0] mdata[32];
  int          mhead = 0, mtail = 0, mcnt = 0;
  int          nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin mvalid[i] = 0; mdone[i] = 0; end
    mhead = 0; mtail = 0; mcnt = 0;
    sbq.delete();
  endtask

  // Check outputs against the model, advance the model, then clock once.
  task automatic step();
    int h1, t0, t1;
    bit e1, e2, erdy, a1, a2;
    exp_t e;
    h1 = (mhead + 1) % 32; t0 = mtail; t1 = (mtail + 1) % 32;
    e1 = (mcnt != 0) && mvalid[mhead] && mdone[mhead];
    e2 = e1 && mvalid[h1] && mdone[h1];
    chk("com_vld_1", o_com_vld_1, e1);
    chk("com_vld_2", o_com_vld_2, e2);
    if (e1 && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("com_addr_1", o_com_rd_wr_addr_1, e.addr);
      chk("com_data_1", o_com_rd_wr_data_1, mdata[e.tag]);
      chk("com_wen_1", o_com_rd_wr_en_1, e.wen);
    end else chk("com_wen_1_idle", o_com_rd_wr_en_1, 0);
    if (e2 && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("com_addr_2", o_com_rd_wr_addr_2, e.addr);
      chk("com_data_2", o_com_rd_wr_data_2, mdata[e.tag]);
      chk("com_wen_2", o_com_rd_wr_en_2, e.wen);
    end else chk("com_wen_2_idle", o_com_rd_wr_en_2, 0);
    erdy = (32 - mcnt) >= 2;
    chk("alloc_rdy", o_dp_alloc_rdy, erdy);
    chk("dp_ptr_1", o_dp_ptr_1, t0);
    chk("dp_ptr_2", o_dp_ptr_2, t1);
    a1 = i_dp_vld_1 && erdy;
    a2 = i_dp_vld_2 && a1;
    if (i_wb_vld_1 && mvalid[i_wb_rrftag_1] && !(a1 && i_wb_rrftag_1 == t0)
        && !(a2 && i_wb_rrftag_1 == t1)) begin
      mdone[i_wb_rrftag_1] = 1; mdata[i_wb_rrftag_1] = i_wb_data_1;
    end
    if (i_wb_vld_2 && mvalid[i_wb_rrftag_2] && !(a1 && i_wb_rrftag_2 == t0)
        && !(a2 && i_wb_rrftag_2 == t1)) begin
      mdone[i_wb_rrftag_2] = 1; mdata[i_wb_rrftag_2] = i_wb_data_2;
    end
    if (e1) begin mvalid[mhead] = 0; mdone[mhead] = 0; end
    if (e2) begin mvalid[h1] = 0; mdone[h1] = 0; end
    if (a1) begin mvalid[t0] = 1; mdone[t0] = 0; sbq.push_back('{t0, i_dp_rd_wr_en_1, i_dp_rd_wr_addr_1}); end
    if (a2) begin mvalid[t1] = 1; mdone[t1] = 0; sbq.push_back('{t1, i_dp_rd_wr_en_2, i_dp_rd_wr_addr_2}); end
    mhead = (mhead + e1 + e2) % 32;
    mtail = (mtail + a1 + a2) % 32;
    mcnt  = mcnt + a1 + a2 - e1 - e2;
    if (i_flush) model_clear();
    @(posedge clk); #1;
    i_dp_vld_1 = 0; i_dp_vld_2 = 0; i_wb_vld_1 = 0; i_wb_vld_2 = 0; i_flush = 0;
  endtask

  task automatic disp(input bit v1, input bit v2, input logic [4:0] ad1, input logic [4:0] ad2);
    i_dp_vld_1 = v1; i_dp_vld_2 = v2;
    i_dp_rd_wr_addr_1 = ad1; i_dp_rd_wr_addr_2 = ad2;
    i_dp_rd_wr_en_1 = 1'($urandom); i_dp_rd_wr_en_2 = 1'($urandom);
    step();
  endtask

  task automatic wb(input bit v1, input int t1, input logic [31:0] d1,
                    input bit v2, input int t2, input logic [31:0] d2);
    i_wb_vld_1 = v1; i_wb_rrftag_1 = 5'(t1); i_wb_data_1 = d1;
    i_wb_vld_2 = v2; i_wb_rrftag_2 = 5'(t2); i_wb_data_2 = d2;
    step();
  endtask

  // Complete every in-flight, not-yet-done entry in shuffled order.
  task automatic wb_pending();
    int tags[$];
    int j, tmp;
    foreach (sbq[i]) if (!mdone[sbq[i].tag]) tags.push_back(sbq[i].tag);
    for (int i = tags.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0); tmp = tags[i]; tags[i] = tags[j]; tags[j] = tmp;
    end
    for (int i = 0; i < tags.size(); i += 2)
      wb(1, tags[i], $urandom, (i + 1 < tags.size()), (i + 1 < tags.size()) ? tags[i+1] : 0, $urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mcnt != 0; i++) step();
    if (mcnt != 0) begin
      nchk++; nerr++;
      $error("FAIL drain_timeout observed=%0d expected=0", mcnt);
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_com_vld_1", o_com_vld_1, 0);
    chk("rst_alloc_rdy", o_dp_alloc_rdy, 1);
    chk("rst_ptr_1", o_dp_ptr_1, 0);
    chk("rst_ptr_2", o_dp_ptr_2, 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // 1: out-of-order writeback, in-order dual commit
    i_dp_vld_1 = 1; i_dp_vld_2 = 1; i_dp_rd_wr_en_1 = 1; i_dp_rd_wr_en_2 = 1;
    i_dp_rd_wr_addr_1 = 5; i_dp_rd_wr_addr_2 = 6;
    step();
    wb(1, 1, 32'hA, 0, 0, 0);
    chk("t1_no_commit", o_com_vld_1, 0);
    wb(1, 0, 32'hB, 0, 0, 0);
    chk("t1_vld_1", o_com_vld_1, 1);
    chk("t1_vld_2", o_com_vld_2, 1);
    chk("t1_addr_1", o_com_rd_wr_addr_1, 5);
    chk("t1_addr_2", o_com_rd_wr_addr_2, 6);
    chk("t1_data_1", o_com_rd_wr_data_1, 32'hB);
    chk("t1_data_2", o_com_rd_wr_data_2, 32'hA);
    step();

    // 2: fill to full, overflow dispatch dropped
    for (int i = 0; i < 16; i++) disp(1, 1, 5'($urandom), 5'($urandom));
    chk("t2_full_rdy", o_dp_alloc_rdy, 0);
    disp(1, 1, 1, 2);
    chk("t2_tail_hold", o_dp_ptr_1, 2);
    wb_pending();
    drain();

    // 3: wrap-around
    for (int i = 0; i < 14; i++) disp(1, 1, 5'($urandom), 5'($urandom));
    wb_pending();
    drain();
    chk("t3_ptr_30", o_dp_ptr_1, 30);
    disp(1, 1, 7, 8);
    chk("t3_ptr_0", o_dp_ptr_1, 0);
    chk("t3_ptr_1", o_dp_ptr_2, 1);
    disp(1, 1, 9, 10);
    wb(1, 30, 32'h30, 0, 0, 0);
    chk("t3_single_1", o_com_vld_1, 1);
    chk("t3_single_2", o_com_vld_2, 0);
    wb(1, 31, 32'h31, 1, 0, 32'h100);
    chk("t3_wrap_1", o_com_vld_1, 1);
    chk("t3_wrap_2", o_com_vld_2, 1);
    chk("t3_wrap_data", o_com_rd_wr_data_2, 32'h100);
    step();
    wb(1, 1, 32'h101, 0, 0, 0);
    drain();

    // 4: count 31, commit 2 while dispatch is dropped
    for (int i = 0; i < 15; i++) disp(1, 1, 5'($urandom), 5'($urandom));
    disp(1, 0, 3, 0);
    wb(1, mhead, 32'h4A, 1, (mhead + 1) % 32, 32'h4B);
    chk("t4_rdy_31", o_dp_alloc_rdy, 0);
    chk("t4_com_2", o_com_vld_2, 1);
    disp(1, 0, 4, 0);
    chk("t4_rdy_29", o_dp_alloc_rdy, 1);
    chk("t4_tail", o_dp_ptr_1, 1);
    wb_pending();
    drain();

    // 6a: flush with in-flight work, commit still fires in the flush cycle
    for (int i = 0; i < 5; i++) disp(1, 1, 5'($urandom), 5'($urandom));
    wb(1, mhead, 32'h61, 1, (mhead + 1) % 32, 32'h62);
    chk("t6_flush_cycle_com", o_com_vld_2, 1);
    i_flush = 1;
    disp(1, 1, 11, 12);
    chk("t6_ptr_1", o_dp_ptr_1, 0);
    chk("t6_ptr_2", o_dp_ptr_2, 1);
    chk("t6_no_com", o_com_vld_1, 0);
    chk("t6_rdy", o_dp_alloc_rdy, 1);
    step();

    // 5: same-tag writeback, unallocated-tag writeback, same-cycle alloc+wb
    disp(1, 1, 20, 21);
    disp(1, 1, 22, 23);
    wb(1, 3, 32'h11, 1, 3, 32'h22);
    wb(1, 10, 32'h55, 0, 0, 0);
    i_wb_vld_1 = 1; i_wb_rrftag_1 = 4; i_wb_data_1 = 32'hBAD;
    disp(1, 1, 24, 25);
    for (int i = 0; i < 3; i++) disp(1, 1, 5'(26 + 2*i), 5'(27 + 2*i));
    wb(1, 0, 32'hF0, 1, 1, 32'hF1);
    wb(1, 2, 32'hF2, 1, 4, 32'hF4);
    wb(1, 5, 32'hF5, 1, 6, 32'hF6);
    wb(1, 7, 32'hF7, 1, 8, 32'hF8);
    wb(1, 9, 32'hF9, 1, 11, 32'hFB);
    for (int i = 0; i < 6; i++) step();
    chk("t5_stall_at_10", o_com_vld_1, 0);
    chk("t5_head_addr", o_com_rd_wr_addr_1, 30);
    wb(1, 10, 32'hFA, 0, 0, 0);
    drain();

    // 6b: async reset mid-run
    for (int i = 0; i < 3; i++) disp(1, 1, 5'($urandom), 5'($urandom));
    wb(1, mhead, 32'h71, 1, (mhead + 1) % 32, 32'h72);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_vld_1", o_com_vld_1, 0);
    chk("rst_mid_vld_2", o_com_vld_2, 0);
    chk("rst_mid_rdy", o_dp_alloc_rdy, 1);
    chk("rst_mid_ptr_1", o_dp_ptr_1, 0);
    chk("rst_mid_ptr_2", o_dp_ptr_2, 1);
    model_clear();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
